// File: rtl/sprite_banner_reader_if.sv
// Scan coordinates in, sprite ROM read port, and banner pixel out to the colour mapper.
// The reader takes the master view; the scan/ROM/mapper environment takes the slave view.
interface sprite_banner_reader_if;
  logic        frame_start;
  logic        show;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [18:0] rom_addr;
  logic [23:0] rom_data;
  logic [23:0] pix_rgb;
  logic        pix_valid;
  logic [1:0]  state;

  modport master (
    input  frame_start, show, DrawX, DrawY, rom_data,
    output rom_addr, pix_rgb, pix_valid, state
  );

  modport slave (
    output frame_start, show, DrawX, DrawY, rom_data,
    input  rom_addr, pix_rgb, pix_valid, state
  );
endinterface

// File: rtl/sprite_banner_reader.sv
// Places a sprite from a registered-output ROM on the scan and blinks it before holding steady.
// Pixel out 3 cycles after its scan coordinate; free-running pipeline, no backpressure or stall.
module sprite_banner_reader #(
  parameter int          SPR_W        = 128,
  parameter int          SPR_H        = 64,
  parameter int          POS_X        = 256,
  parameter int          POS_Y        = 208,
  parameter int          BLINK_FRAMES = 30,
  parameter int          BLINK_COUNT  = 3,
  parameter logic [23:0] KEY_RGB      = 24'hFFFFFF
) (
  input logic                    Clk,
  input logic                    Reset_n,
  sprite_banner_reader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ON     = 2'd1,
    OFF    = 2'd2,
    STEADY = 2'd3
  } state_t;

  localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int BCW = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(BLINK_FRAMES - 1);
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_COUNT - 1);

  // 11-bit window bounds so POS + SPR never wraps against a 10-bit scan coordinate.
  localparam logic [10:0] X_LO = 11'(POS_X);
  localparam logic [10:0] X_HI = 11'(POS_X + SPR_W);
  localparam logic [10:0] Y_LO = 11'(POS_Y);
  localparam logic [10:0] Y_HI = 11'(POS_Y + SPR_H);
  localparam logic [18:0] W19  = 19'(SPR_W);

  state_t         state_q, state_d;
  logic [FCW-1:0] frame_q, frame_d;
  logic [BCW-1:0] blink_q, blink_d;

  logic [10:0] x11, y11, dx, dy;
  logic        in_win;
  logic        visible;
  logic [18:0] addr_d;

  logic [18:0] rom_addr_q;
  logic        vis1_q, vis2_q;
  logic [23:0] pix_rgb_q;
  logic        pix_valid_q;

  assign x11    = {1'b0, bus.DrawX};
  assign y11    = {1'b0, bus.DrawY};
  assign in_win = (x11 >= X_LO) && (x11 < X_HI) && (y11 >= Y_LO) && (y11 < Y_HI);
  assign dx     = x11 - X_LO;
  assign dy     = y11 - Y_LO;
  assign addr_d = ({8'd0, dy} * W19) + {8'd0, dx};

  assign visible = (state_q == ON) || (state_q == STEADY);

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    blink_d = blink_q;
    if (!bus.show) begin
      state_d = IDLE;
      frame_d = '0;
      blink_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // The frame_start coinciding with show rising is deliberately not counted.
          state_d = ON;
          frame_d = '0;
          blink_d = '0;
        end
        ON: begin
          if (bus.frame_start) begin
            if (frame_q == FRAME_LAST) begin
              state_d = OFF;
              frame_d = '0;
            end else begin
              frame_d = frame_q + 1'b1;
            end
          end
        end
        OFF: begin
          if (bus.frame_start) begin
            if (frame_q == FRAME_LAST) begin
              frame_d = '0;
              if (blink_q == BLINK_LAST) begin
                state_d = STEADY;
              end else begin
                state_d = ON;
                blink_d = blink_q + 1'b1;
              end
            end else begin
              frame_d = frame_q + 1'b1;
            end
          end
        end
        STEADY:  state_d = STEADY;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      blink_q     <= '0;
      rom_addr_q  <= '0;
      vis1_q      <= 1'b0;
      vis2_q      <= 1'b0;
      pix_rgb_q   <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      blink_q     <= blink_d;
      rom_addr_q  <= in_win ? addr_d : '0;
      vis1_q      <= in_win && visible;
      // rom_data now belongs to the address registered one edge ago, aligned with vis2.
      vis2_q      <= vis1_q;
      pix_valid_q <= vis2_q && (bus.rom_data != KEY_RGB);
      pix_rgb_q   <= vis2_q ? bus.rom_data : '0;
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.pix_rgb   = pix_rgb_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_sprite_banner_reader.sv
// Directed plus randomized bench for sprite_banner_reader against a frame-count reference model.
module tb_sprite_banner_reader;
  localparam int          PX  = 256;
  localparam int          PY  = 208;
  localparam int          W   = 128;
  localparam int          H   = 64;
  localparam int          BF  = 2;
  localparam int          BC  = 2;
  localparam logic [23:0] KEY = 24'hFFFFFF;

  typedef struct {
    logic        v;
    logic [23:0] rgb;
  } pix_t;

  logic Clk = 1'b0;
  logic Reset_n;
  sprite_banner_reader_if bus ();

  logic [23:0] rom_mem [0:8191];
  pix_t        q[$];
  bit          m_active;
  int          m_n;
  int          n_assert;
  int          n_fail;

  sprite_banner_reader #(
    .SPR_W(W), .SPR_H(H), .POS_X(PX), .POS_Y(PY),
    .BLINK_FRAMES(BF), .BLINK_COUNT(BC), .KEY_RGB(KEY)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  // Single-port ROM with one cycle of registered read latency.
  always @(posedge Clk) bus.rom_data <= rom_mem[bus.rom_addr[12:0]];

  // Display phase follows from how many frames were counted since show rose.
  function automatic int model_state();
    int ph;
    if (!m_active) return 0;
    ph = m_n / BF;
    if (ph >= 2 * BC) return 3;
    return (ph % 2 == 0) ? 1 : 2;
  endfunction

  function automatic int rand_x();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 639));
    return int'($urandom_range(PX - 4, PX + W + 3));
  endfunction

  function automatic int rand_y();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 479));
    return int'($urandom_range(PY - 4, PY + H + 3));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic sh, input logic fs, input int x, input int y);
    pix_t e;
    pix_t zp;
    bit   win;
    bit   vis;
    int   a;
    int   ms;
    zp.v   = 1'b0;
    zp.rgb = 24'h0;
    Reset_n         = rst;
    bus.show        = sh;
    bus.frame_start = fs;
    bus.DrawX       = 10'(x);
    bus.DrawY       = 10'(y);
    @(posedge Clk);
    win = (x >= PX) && (x < PX + W) && (y >= PY) && (y < PY + H);
    a   = win ? (y - PY) * W + (x - PX) : 0;
    ms  = model_state();
    if (!rst) begin
      a = 0;
      q.delete();
      repeat (3) q.push_back(zp);
      m_active = 1'b0;
      m_n      = 0;
    end else begin
      vis   = win && (ms == 1 || ms == 3);
      e.v   = vis && (rom_mem[a] != KEY);
      e.rgb = vis ? rom_mem[a] : 24'h0;
      q.push_back(e);
      if (q.size() > 3) void'(q.pop_front());
      if (!sh) begin
        m_active = 1'b0;
        m_n      = 0;
      end else if (!m_active) begin
        m_active = 1'b1;
        m_n      = 0;
      end else if (fs && ms != 3) begin
        m_n++;
      end
    end
    #1;
    chk("rom_addr", 32'(bus.rom_addr), 32'(a));
    chk("pix_valid", 32'(bus.pix_valid), 32'(q[0].v));
    chk("pix_rgb", 32'(bus.pix_rgb), 32'(q[0].rgb));
    chk("state", 32'(bus.state), 32'(model_state()));
  endtask

  initial begin
    int exp_seq [9];
    int ex [4];
    int ey [4];
    exp_seq = '{1, 1, 2, 2, 1, 1, 2, 2, 3};
    ex = '{255, 384, 256, 256};
    ey = '{208, 208, 207, 272};
    n_assert = 0;
    n_fail   = 0;
    m_active = 1'b0;
    m_n      = 0;
    for (int i = 0; i < 8192; i++)
      rom_mem[i] = ($urandom_range(0, 3) == 0) ? KEY : 24'($urandom);
    rom_mem[0]    = 24'h000000;
    rom_mem[8191] = 24'h000000;
    rom_mem[5]    = KEY;

    // Reset
    repeat (3) step(1'b0, 1'b0, 1'b0, 300, 220);
    chk("reset_valid", 32'(bus.pix_valid), 32'd0);
    chk("reset_rgb", 32'(bus.pix_rgb), 32'd0);
    chk("reset_state", 32'(bus.state), 32'd0);

    // Coordinate mapping and 3-cycle latency
    step(1'b1, 1'b1, 1'b0, 256, 208);
    chk("addr_first", 32'(bus.rom_addr), 32'd0);
    chk("state_on", 32'(bus.state), 32'd1);
    step(1'b1, 1'b1, 1'b0, 256, 208);
    step(1'b1, 1'b1, 1'b0, 383, 271);
    chk("addr_last", 32'(bus.rom_addr), 32'd8191);
    step(1'b1, 1'b1, 1'b0, 0, 0);
    chk("lat_valid", 32'(bus.pix_valid), 32'd1);
    chk("lat_rgb", 32'(bus.pix_rgb), 32'd0);
    step(1'b1, 1'b1, 1'b0, 0, 0);
    chk("lat_valid_last", 32'(bus.pix_valid), 32'd1);

    // Window edges
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, ex[i], ey[i]);
      chk("edge_addr", 32'(bus.rom_addr), 32'd0);
      step(1'b1, 1'b1, 1'b0, 0, 0);
      step(1'b1, 1'b1, 1'b0, 0, 0);
      chk("edge_valid", 32'(bus.pix_valid), 32'd0);
    end

    // Transparent colour key
    step(1'b1, 1'b1, 1'b0, 261, 208);
    step(1'b1, 1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 1'b0, 0, 0);
    chk("key_valid", 32'(bus.pix_valid), 32'd0);
    chk("key_rgb", 32'(bus.pix_rgb), 32'hFFFFFF);

    // Random traffic while ON
    repeat (40) step(1'b1, 1'b1, 1'b0, rand_x(), rand_y());

    // Blink sequence; pulse 0 coincides with show rising
    step(1'b1, 1'b0, 1'b0, rand_x(), rand_y());
    step(1'b1, 1'b1, 1'b1, rand_x(), rand_y());
    chk("blink_seq", 32'(bus.state), 32'(exp_seq[0]));
    for (int p = 1; p < 9; p++) begin
      repeat ($urandom_range(2, 4)) step(1'b1, 1'b1, 1'b0, rand_x(), rand_y());
      step(1'b1, 1'b1, 1'b1, rand_x(), rand_y());
      chk("blink_seq", 32'(bus.state), 32'(exp_seq[p]));
    end
    repeat (20) step(1'b1, 1'b1, $urandom_range(0, 1) == 1, rand_x(), rand_y());
    chk("steady_hold", 32'(bus.state), 32'd3);

    // Abort during OFF together with frame_start, then restart
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b1, 1'b0, rand_x(), rand_y());
    step(1'b1, 1'b1, 1'b1, rand_x(), rand_y());
    step(1'b1, 1'b1, 1'b1, rand_x(), rand_y());
    chk("abort_pre_off", 32'(bus.state), 32'd2);
    step(1'b1, 1'b1, 1'b0, rand_x(), rand_y());
    step(1'b1, 1'b0, 1'b1, rand_x(), rand_y());
    chk("abort_idle", 32'(bus.state), 32'd0);
    step(1'b1, 1'b1, 1'b0, rand_x(), rand_y());
    chk("restart_on", 32'(bus.state), 32'd1);
    step(1'b1, 1'b1, 1'b1, rand_x(), rand_y());
    chk("restart_pulse1", 32'(bus.state), 32'd1);
    step(1'b1, 1'b1, 1'b1, rand_x(), rand_y());
    chk("restart_pulse2", 32'(bus.state), 32'd2);

    // Run on to STEADY, then reset with visible pixels in flight
    repeat (6) begin
      step(1'b1, 1'b1, 1'b0, rand_x(), rand_y());
      step(1'b1, 1'b1, 1'b1, rand_x(), rand_y());
    end
    chk("steady_again", 32'(bus.state), 32'd3);
    step(1'b1, 1'b1, 1'b0, 256, 208);
    step(1'b1, 1'b1, 1'b0, 383, 271);
    step(1'b0, 1'b1, 1'b0, 256, 208);
    chk("midrst_state", 32'(bus.state), 32'd0);
    chk("midrst_valid", 32'(bus.pix_valid), 32'd0);
    repeat (4) begin
      step(1'b1, 1'b1, 1'b0, 0, 0);
      chk("post_rst_valid", 32'(bus.pix_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sprite_banner_reader.md
Name: sprite_banner_reader

Overview:
- Read-side initiator for the single-port sprite frame ROMs (e.g. the Game Over/Draw banner ROMs).
- Takes VGA scan coordinates and positions a SPR_W x SPR_H sprite at (POS_X, POS_Y).
- Generates the ROM read address and absorbs the ROM's 1-cycle registered-output latency.
- Emits an aligned pixel colour and valid flag to the colour mapper, with a frame-counted blink-then-steady display sequence.

Parameters:
- SPR_W, 128: sprite width in pixels.
- SPR_H, 64: sprite height in pixels. SPR_W*SPR_H must be <= 8192.
- POS_X, 256: screen X of the sprite's top-left pixel.
- POS_Y, 208: screen Y of the sprite's top-left pixel.
- BLINK_FRAMES, 30: frames per blink half-period, >= 1.
- BLINK_COUNT, 3: number of on/off blink pairs before steady display, >= 1.
- KEY_RGB, 24'hFFFFFF: transparent colour key.

Ports:
- Clk, input, 1: system clock. All logic on the rising edge.
- Reset_n, input, 1: reset, synchronous, active-low.
- frame_start, input, 1: one-cycle pulse at the start of each frame.
- show, input, 1: level; the game has ended and the banner is requested.
- DrawX, input, 10: current scan X.
- DrawY, input, 10: current scan Y.
- rom_addr, output, 19: read address to the sprite ROM.
- rom_data, input, 24: ROM colour; it is the data for the rom_addr presented one cycle earlier.
- pix_rgb, output, 24: banner pixel colour.
- pix_valid, output, 1: 1 means the mapper uses pix_rgb instead of the background.
- state, output, 2: FSM state encoding (IDLE=0, ON=1, OFF=2, STEADY=3), for debug.

Behaviour:
- Reset (Reset_n=0 at a rising edge) sets every register to:
  - rom_addr=0, pix_rgb=0, pix_valid=0, state=IDLE;
  - frame counter=0, blink counter=0;
  - pipeline flags=0.
  - Reset overrides all other inputs, including mid-sequence.
- Window test:
  - in_win = (DrawX >= POS_X) & (DrawX < POS_X+SPR_W) & (DrawY >= POS_Y) & (DrawY < POS_Y+SPR_H).
  - Compare in 11-bit unsigned arithmetic so POS+SPR cannot wrap.
- Stage 1 (registered):
  - rom_addr <= in_win ? (DrawY-POS_Y)*SPR_W + (DrawX-POS_X), zero-extended to 19 bits : 0.
  - vis1 <= in_win & visible, where visible = (state==ON) | (state==STEADY), evaluated in that cycle.
- Stage 2 (registered): vis2 <= vis1. The ROM returns the data for stage-1 rom_addr on this same edge.
- Stage 3 (registered):
  - pix_valid <= vis2 & (rom_data != KEY_RGB).
  - pix_rgb <= vis2 ? rom_data : 0.
- Latency: pix_rgb/pix_valid at cycle t+3 correspond to DrawX/DrawY at cycle t. The upstream scan timing compensates. The pipeline advances every cycle and has no stall.
- FSM transitions, in priority order:
  - show=0 in any state -> IDLE next cycle; clear both counters.
  - IDLE: show=1 -> ON; frame counter=0, blink counter=0.
  - ON: on frame_start, if frame counter==BLINK_FRAMES-1 -> OFF and clear the frame counter; else increment the frame counter.
  - OFF: on frame_start with frame counter==BLINK_FRAMES-1:
    - if blink counter==BLINK_COUNT-1 -> STEADY;
    - else -> ON and increment the blink counter;
    - in both cases clear the frame counter.
  - OFF: on frame_start otherwise, increment the frame counter.
  - STEADY: hold while show=1.
- Boundaries:
  - frame_start in the same cycle that show rises is not counted; the first counted frame_start is the next one.
  - show=0 together with frame_start: the show=0 rule wins.
  - show re-asserted after IDLE restarts the full blink sequence.
  - Pixels already in the pipeline drain with their stage-1 visibility. There is no mid-pipeline blanking, so a state change affects output exactly 3 cycles later.

Test Plan:
- Reset, coordinate mapping and latency: hold Reset_n=0 for 3 cycles -> all outputs 0, state=0. Then release, show=1, DrawX=256, DrawY=208 -> rom_addr=0 after 1 cycle. DrawX=383, DrawY=271 -> rom_addr=8191. A ROM model returning 24'h000000 gives pix_valid=1, pix_rgb=0 exactly 3 cycles after the coordinate.
- Window edges: DrawX=255 or 384, or DrawY=207 or 272 -> rom_addr=0, pix_valid=0 three cycles later.
- Transparency: in window, state ON, rom_data=24'hFFFFFF -> pix_valid=0, pix_rgb=24'hFFFFFF. With rom_data=24'h000000 -> pix_valid=1.
- Blink sequence, BLINK_FRAMES=2 and BLINK_COUNT=2: show=1, then frame_start pulses -> state ON, ON, OFF, OFF, ON, ON, OFF, OFF, STEADY after pulses 0..8. State is STEADY after the 8th pulse; pix_valid is 0 throughout OFF.
- Abort: show=0 during OFF, in the same cycle as frame_start -> state=IDLE next cycle. Show=1 again -> state=ON with counters cleared, so 2 pulses are needed to reach OFF.
- Reset mid-operation: Reset_n=0 in STEADY while pixels are in flight -> state=IDLE and pix_valid=0 at the next edge, with no stale pixel after release.
